// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM states,
// access sizes and the request decode helpers.
package load_store_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE,
        ST_FAULT
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_NONE,
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } access_size_e;

    // SZ_NONE doubles as the "illegal code" marker; stores have no unsigned forms.
    function automatic access_size_e decode_size(input logic is_store, input logic [2:0] funct3);
        access_size_e sz;
        sz = SZ_NONE;
        case (funct3)
            F3_LB:   sz = SZ_BYTE;
            F3_LH:   sz = SZ_HALF;
            F3_LW:   sz = SZ_WORD;
            F3_LBU:  sz = is_store ? SZ_NONE : SZ_BYTE;
            F3_LHU:  sz = is_store ? SZ_NONE : SZ_HALF;
            default: sz = SZ_NONE;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(input access_size_e sz, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (sz)
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = |addr_lo;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave).
interface load_store_unit_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 20
);
    logic [DEPTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_wr;
    logic             mem_rd;
    logic             mem_one_byte;
    logic             mem_two_bytes;
    logic             mem_four_bytes;

    modport master (
        output mem_addr, mem_wdata, mem_wr, mem_rd,
        output mem_one_byte, mem_two_bytes, mem_four_bytes,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_wr, mem_rd,
        input  mem_one_byte, mem_two_bytes, mem_four_bytes,
        output mem_rdata
    );
endinterface

// File: rtl/load_store_unit_load_extend.sv
// Combinational load-result extension: sign/zero-extends byte and halfword
// loads to WIDTH bits, passes words through.
module load_extend
    import load_store_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] ext
);
    logic w_is_byte;
    logic w_is_half;
    logic w_fill8;
    logic w_fill16;

    assign w_is_byte = (funct3 == F3_LB) || (funct3 == F3_LBU);
    assign w_is_half = (funct3 == F3_LH) || (funct3 == F3_LHU);
    assign w_fill8   = (funct3 == F3_LB) & raw[7];
    assign w_fill16  = (funct3 == F3_LH) & raw[15];

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi < 8) begin : g_low
                assign ext[gi] = raw[gi];
            end else if (gi < 16) begin : g_mid
                assign ext[gi] = w_is_byte ? w_fill8 : raw[gi];
            end else begin : g_high
                assign ext[gi] = w_is_byte ? w_fill8 : (w_is_half ? w_fill16 : raw[gi]);
            end
        end
    endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Single-request load/store unit: latches one RV32I load/store, checks it,
// drives one memory access cycle and reports completion or a fault.
module load_store_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                is_store,
    input  logic [2:0]          funct3,
    input  logic [31:0]         addr_in,
    input  logic [WIDTH-1:0]    wdata_in,
    load_store_unit_if.master   mem,
    output logic [WIDTH-1:0]    rdata_out,
    output logic                busy,
    output logic                done,
    output logic                misaligned,
    output logic                illegal
);
    import load_store_unit_pkg::*;

    lsu_state_e       r_state;
    lsu_state_e       w_state_next;
    access_size_e     r_size;
    logic             r_is_store;
    logic [2:0]       r_funct3;
    logic [DEPTH-1:0] r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic [WIDTH-1:0] r_rdata;
    logic             r_misaligned;
    logic             r_illegal;

    access_size_e     w_size;
    logic             w_illegal;
    logic             w_misaligned;
    logic             w_accept;
    logic             w_access;
    logic             w_finish;
    logic [WIDTH-1:0] w_ext;
    logic             w_unused_addr_hi;

    assign w_size       = decode_size(is_store, funct3);
    assign w_illegal    = (w_size == SZ_NONE);
    assign w_misaligned = !w_illegal && is_misaligned(w_size, addr_in[1:0]);
    assign w_accept     = (r_state == ST_IDLE) && start;
    // High address bits are deliberately dropped so accesses wrap in the memory.
    assign w_unused_addr_hi = ^addr_in;

    load_extend #(.WIDTH(WIDTH)) u_load_extend (
        .funct3 (r_funct3),
        .raw    (mem.mem_rdata),
        .ext    (w_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_size       <= SZ_NONE;
            r_is_store   <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_misaligned <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_size       <= w_size;
                r_is_store   <= is_store;
                r_funct3     <= funct3;
                r_addr       <= addr_in[DEPTH-1:0];
                r_wdata      <= wdata_in;
                r_misaligned <= w_misaligned;
                r_illegal    <= w_illegal;
            end
            if ((r_state == ST_ACCESS) && !r_is_store) begin
                r_rdata <= w_ext;
            end
        end
    end

    always_comb begin
        w_state_next        = r_state;
        w_access            = (r_state == ST_ACCESS);
        w_finish            = (r_state == ST_DONE) || (r_state == ST_FAULT);
        mem.mem_addr        = r_addr;
        mem.mem_wdata       = r_wdata;
        mem.mem_rd          = 1'b0;
        mem.mem_wr          = 1'b0;
        mem.mem_one_byte    = 1'b0;
        mem.mem_two_bytes   = 1'b0;
        mem.mem_four_bytes  = 1'b0;
        rdata_out           = r_rdata;
        busy                = (r_state != ST_IDLE);
        done                = 1'b0;
        misaligned          = 1'b0;
        illegal             = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = (w_illegal || w_misaligned) ? ST_FAULT : ST_ACCESS;
                end
            end
            ST_ACCESS: w_state_next = ST_DONE;
            ST_DONE:   w_state_next = ST_IDLE;
            ST_FAULT:  w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase

        if (w_access) begin
            mem.mem_rd         = !r_is_store;
            mem.mem_wr         = r_is_store;
            mem.mem_one_byte   = (r_size == SZ_BYTE);
            mem.mem_two_bytes  = (r_size == SZ_HALF);
            mem.mem_four_bytes = (r_size == SZ_WORD);
        end

        // Fault flags are only meaningful alongside the completion pulse.
        if (w_finish) begin
            done       = 1'b1;
            misaligned = r_misaligned;
            illegal    = r_illegal;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a byte-addressed memory model
// and a scoreboard of expected completions.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 20;
    localparam int AMASK = (1 << DEPTH) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              is_store;
    logic [2:0]        funct3;
    logic [31:0]       addr_in;
    logic [WIDTH-1:0]  wdata_in;
    logic [WIDTH-1:0]  rdata_out;
    logic              busy;
    logic              done;
    logic              misaligned;
    logic              illegal;

    load_store_unit_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    load_store_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr_in    (addr_in),
        .wdata_in   (wdata_in),
        .mem        (bus.master),
        .rdata_out  (rdata_out),
        .busy       (busy),
        .done       (done),
        .misaligned (misaligned),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [7:0] mem_bytes [int];

    function automatic logic [7:0] rd_byte(input int a);
        int b;
        b = a & AMASK;
        if (mem_bytes.exists(b)) return mem_bytes[b];
        return 8'h00;
    endfunction

    function automatic logic [31:0] rd_word(input int a);
        return {rd_byte(a + 3), rd_byte(a + 2), rd_byte(a + 1), rd_byte(a)};
    endfunction

    always @(negedge clk) begin
        int wa;
        wa = int'(bus.mem_addr);
        if (bus.mem_wr === 1'b1) begin
            mem_bytes[wa & AMASK] = bus.mem_wdata[7:0];
            if (bus.mem_two_bytes || bus.mem_four_bytes)
                mem_bytes[(wa + 1) & AMASK] = bus.mem_wdata[15:8];
            if (bus.mem_four_bytes) begin
                mem_bytes[(wa + 2) & AMASK] = bus.mem_wdata[23:16];
                mem_bytes[(wa + 3) & AMASK] = bus.mem_wdata[31:24];
            end
        end
        bus.mem_rdata = rd_word(wa);
    end

    // ---------------- checking ----------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        mis;
        logic        ill;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] hold_rdata;

    function automatic logic [4:0] exp_strobes(input logic st, input logic [2:0] f3);
        logic b, h, w;
        b = (f3 == 3'b000) || (f3 == 3'b100);
        h = (f3 == 3'b001) || (f3 == 3'b101);
        w = (f3 == 3'b010);
        return {~st, st, b, h, w};
    endfunction

    task automatic pop_and_check(input string name, input int k);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val({name, " unexpected done"}, 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        check_val({name, " latency"}, 32'(k), 32'(e.lat));
        check_val({name, " rdata"}, rdata_out, e.rdata);
        check_val({name, " misaligned"}, 32'(misaligned), 32'(e.mis));
        check_val({name, " illegal"}, 32'(illegal), 32'(e.ill));
        $display("txn %-12s st=%0d f3=%03b addr=0x%08h rdata=0x%08h mis=%0d ill=%0d lat=%0d",
                 name, e.st, e.f3, e.addr, rdata_out, misaligned, illegal, k);
    endtask

    task automatic do_req(input string name, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] ld_val, input logic mis, input logic ill);
        exp_t e;
        bit   seen;
        e.st    = st;
        e.f3    = f3;
        e.addr  = addr;
        e.mis   = mis;
        e.ill   = ill;
        e.lat   = (mis || ill) ? 1 : 2;
        if (!st && !mis && !ill) hold_rdata = ld_val;
        e.rdata = hold_rdata;
        sb_q.push_back(e);

        @(negedge clk);
        start    = 1'b1;
        is_store = st;
        funct3   = f3;
        addr_in  = addr;
        wdata_in = wdata;
        seen     = 0;
        for (int k = 1; k <= 8 && !seen; k++) begin
            @(negedge clk);
            start = 1'b0;
            check_val({name, " strobes"},
                      32'({bus.mem_rd, bus.mem_wr, bus.mem_one_byte, bus.mem_two_bytes, bus.mem_four_bytes}),
                      32'((k == 1 && e.lat == 2) ? exp_strobes(st, f3) : 5'b0));
            if (k == 1 && e.lat == 2) begin
                check_val({name, " mem_addr"}, 32'(bus.mem_addr), addr & 32'(AMASK));
                if (st) check_val({name, " mem_wdata"}, bus.mem_wdata, wdata);
            end
            check_val({name, " busy"}, 32'(busy), 32'd1);
            if (done) begin
                seen = 1;
                pop_and_check(name, k);
            end else begin
                check_val({name, " flags idle"}, 32'({misaligned, illegal}), 32'd0);
            end
        end
        if (!seen) check_val({name, " timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_done;
        exp_t e;
        rst        = 1'b1;
        start      = 1'b0;
        is_store   = 1'b0;
        funct3     = 3'b000;
        addr_in    = 32'h0;
        wdata_in   = '0;
        hold_rdata = 32'h0;

        @(negedge clk);
        check_val("rst rdata", rdata_out, 32'h0);
        check_val("rst busy_done", 32'({busy, done, misaligned, illegal}), 32'd0);
        check_val("rst strobes",
                  32'({bus.mem_rd, bus.mem_wr, bus.mem_one_byte, bus.mem_two_bytes, bus.mem_four_bytes}), 32'd0);
        check_val("rst mem_addr", 32'(bus.mem_addr), 32'h0);
        check_val("rst mem_wdata", bus.mem_wdata, 32'h0);
        // rst must win over a simultaneous start
        start = 1'b1;
        @(negedge clk);
        check_val("rst prio busy", 32'(busy), 32'd0);
        start = 1'b0;
        rst   = 1'b0;

        do_req("SW 100",    1'b1, F3_SW,  32'h00100, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0);
        do_req("LW 100",    1'b0, F3_LW,  32'h00100, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0);
        do_req("LB 100",    1'b0, F3_LB,  32'h00100, 32'h0,        32'hFFFFFFEF, 1'b0, 1'b0);
        do_req("LBU 100",   1'b0, F3_LBU, 32'h00100, 32'h0,        32'h000000EF, 1'b0, 1'b0);
        do_req("LH 102",    1'b0, F3_LH,  32'h00102, 32'h0,        32'hFFFFDEAD, 1'b0, 1'b0);
        do_req("LHU 102",   1'b0, F3_LHU, 32'h00102, 32'h0,        32'h0000DEAD, 1'b0, 1'b0);
        do_req("LW 102 mis",1'b0, F3_LW,  32'h00102, 32'h0,        32'h0,        1'b1, 1'b0);
        do_req("SH 101 mis",1'b1, F3_SH,  32'h00101, 32'h11112222, 32'h0,        1'b1, 1'b0);
        do_req("S 011 ill", 1'b1, 3'b011, 32'h00103, 32'h33334444, 32'h0,        1'b0, 1'b1);
        do_req("L 110 ill", 1'b0, 3'b110, 32'h00101, 32'h0,        32'h0,        1'b0, 1'b1);
        do_req("SB 104",    1'b1, F3_SB,  32'h00104, 32'hCAFE0055, 32'h0,        1'b0, 1'b0);
        do_req("SH 106",    1'b1, F3_SH,  32'h00106, 32'hFFFFA1B2, 32'h0,        1'b0, 1'b0);
        do_req("LW 104",    1'b0, F3_LW,  32'h00104, 32'h0,        32'hA1B20055, 1'b0, 1'b0);
        do_req("LB 107",    1'b0, F3_LB,  32'h00107, 32'h0,        32'hFFFFFFA1, 1'b0, 1'b0);
        do_req("LW wrap",   1'b0, F3_LW,  32'hFFF00100, 32'h0,     32'hDEADBEEF, 1'b0, 1'b0);

        // start held through ACCESS and DONE must not launch a second request
        e.st = 1'b0; e.f3 = F3_LW; e.addr = 32'h00100; e.rdata = 32'hDEADBEEF;
        e.mis = 1'b0; e.ill = 1'b0; e.lat = 2;
        hold_rdata = 32'hDEADBEEF;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; funct3 = F3_LW; addr_in = 32'h00100; wdata_in = '0;
        n_done = 0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) begin
                is_store = 1'b1; funct3 = F3_SW; addr_in = 32'h00200; wdata_in = 32'h12345678;
            end
            if (k == 3) start = 1'b0;
            if (done) begin
                n_done++;
                pop_and_check("LW busy-start", k);
            end
            if (k >= 3) check_val("busy-start idle", 32'(busy), 32'd0);
        end
        check_val("busy-start done count", 32'(n_done), 32'd1);
        check_val("busy-start no store", rd_word(32'h200), 32'h0);

        // reset in the middle of a load's ACCESS cycle
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; funct3 = F3_LW; addr_in = 32'h00004;
        @(negedge clk);
        start = 1'b0;
        check_val("rst-access rd", 32'(bus.mem_rd), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("rst-access busy", 32'(busy), 32'd0);
        check_val("rst-access done", 32'(done), 32'd0);
        check_val("rst-access rdata", rdata_out, 32'h0);
        @(negedge clk);
        check_val("rst-access no done", 32'(done), 32'd0);
        hold_rdata = 32'h0;
        do_req("LW after rst", 1'b0, F3_LW, 32'h00100, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);

        check_val("scoreboard empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter WIDTH, default 32: data width.
REQ-002 Parameter DEPTH, default 20: data-memory address width in bits (byte-addressed).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  request pulse; sampled only in IDLE.
REQ-006 is_store  in  1  1 = store, 0 = load; sampled with start.
REQ-007 funct3  in  3  RV32I width/sign code; sampled with start.
REQ-008 addr_in  in  32  effective byte address; sampled with start.
REQ-009 wdata_in  in  WIDTH  store data; sampled with start.
REQ-010 mem_rdata  in  WIDTH  combinational read data from data memory.
REQ-011 mem_addr  out  DEPTH  byte address to data memory, equal to latched addr[DEPTH-1:0].
REQ-012 mem_wdata  out  WIDTH  latched store data, unshifted.
REQ-013 mem_wr, mem_rd  out  1 each  write and read strobes.
REQ-014 mem_one_byte, mem_two_bytes, mem_four_bytes  out  1 each  one-hot size select.
REQ-015 rdata_out  out  WIDTH  extended load result, held until next load completes.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle completion pulse.
REQ-018 misaligned, illegal  out  1 each  fault flags, valid only while done=1.

Function
REQ-019 FSM states are IDLE, ACCESS, DONE, FAULT.
- IDLE + start: latch all inputs.
- Legal and aligned -> ACCESS; otherwise -> FAULT.
- ACCESS -> DONE unconditionally.
- DONE -> IDLE; FAULT -> IDLE.
REQ-020 Legal codes:
- Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Stores: 000 SB, 001 SH, 010 SW.
- Any other code sets illegal=1.
REQ-021 Alignment:
- Halfword requires addr[0]=0.
- Word requires addr[1:0]=00.
- Violation sets misaligned=1.
- If the code is illegal, illegal=1 and misaligned=0.
REQ-022 In ACCESS only:
- Exactly one of mem_rd/mem_wr is high, selected by is_store.
- Exactly one size select is high: byte for 000/100, half for 001/101, word for 010.
- All strobes are low in every other state.
REQ-023 Memory writes on the falling edge of clk, so a store completes inside the ACCESS cycle.
REQ-024 A load captures mem_rdata into rdata_out at the rising edge that ends ACCESS.
- LB sign-extends bit 7; LH sign-extends bit 15.
- LBU and LHU zero-extend; LW passes through.
REQ-025 Latency:
- start sampled at edge N; ACCESS during cycle N+1; done=1 during cycle N+2.
- A fault gives done=1 during cycle N+1 with no memory strobe.
REQ-026 Stores and faults leave rdata_out unchanged.
REQ-027 start while busy=1 is ignored and not queued; the next request is accepted in the cycle after done.
REQ-028 addr_in bits above DEPTH-1 are discarded without fault, so the address wraps modulo 2**DEPTH.
REQ-029 The misaligned and illegal flags are low whenever done=0.

Reset
REQ-030 rst=1 at a rising edge forces IDLE with all outputs 0: rdata_out, done, busy, flags, strobes and mem_addr/mem_wdata latches.
REQ-031 Reset mid-ACCESS aborts the request and produces no done pulse.
- A store's falling-edge write in that cycle completes, since rst takes effect at the next rising edge.
REQ-032 rst has priority over start in the same cycle.

Structure
REQ-033 A shared package holds:
- funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
- The FSM state enum.
- The access-size enum.
REQ-034 A pure combinational sub-module load_extend (funct3, raw data -> extended data) is the only sub-module.

Verification
REQ-035 SW 0xDEADBEEF to 0x00100, then LW 0x00100 -> done at N+2; rdata_out=0xDEADBEEF; mem_four_bytes high only in ACCESS.
REQ-036 With memory at 0x00100 = EF,BE,AD,DE:
- LB 0x00100 -> 0xFFFFFFEF.
- LBU 0x00100 -> 0x000000EF.
- LH 0x00102 -> 0xFFFFDEAD.
- LHU 0x00102 -> 0x0000DEAD.
REQ-037 LW 0x00102 -> done and misaligned at N+1; mem_rd never asserted; rdata_out unchanged.
REQ-038 funct3=011 with is_store=1 -> illegal=1, misaligned=0; mem_wr never asserted.
REQ-039 start pulsed in ACCESS and DONE of a load -> exactly one done pulse, and only one request performed.
REQ-040 rst during ACCESS of a load from 0x00004 -> next cycle busy=0, done=0, rdata_out=0; a fresh LW is then accepted normally.
